// File: rtl/hyperbus_txn_arbiter.sv
// hyperbus_txn_arbiter
// Round-robin arbiter that shares one HyperBus transaction engine between
// NR_REQ requesters. It grants one transaction at a time, holds the grant
// until the engine reports completion, and then enforces the chip-select
// recovery gap (T_RWR cycles) before the next grant.
//
// Optional build macro: HYPERBUS_ARB_TIMEOUT_EN
//   When defined, a BUSY watchdog aborts a transaction after TIMEOUT_CYCLES
//   and pulses timeout_o. When undefined, no counter is built and timeout_o
//   is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction owned; the round-robin winner is accepted
// ISSUE   | command presented to the engine, waiting for txn_ready_i
// BUSY    | engine owns the command, waiting for txn_done_i
// RECOVER | chip-select recovery gap after completion, no new grant

module hyperbus_txn_arbiter #(
  parameter int NR_REQ         = 3,
  parameter int NR_CS          = 2,
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int T_RWR          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CS_W          = (NR_CS > 1) ? $clog2(NR_CS) : 1,
  localparam int ID_W          = $clog2(NR_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  logic [NR_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NR_REQ-1:0]        req_write_i,
  input  logic [NR_REQ*LEN_W-1:0]  req_len_i,
  input  logic [NR_REQ*CS_W-1:0]   req_cs_i,
  output logic                     txn_valid_o,
  input  logic                     txn_ready_i,
  output logic [ADDR_W-1:0]        txn_addr_o,
  output logic                     txn_write_o,
  output logic [LEN_W-1:0]         txn_len_o,
  output logic [CS_W-1:0]          txn_cs_o,
  output logic [ID_W-1:0]          txn_id_o,
  input  logic                     txn_done_i,
  output logic                     busy_o,
  output logic                     timeout_o
);

  // Recovery counter must hold T_RWR; keep at least one bit when T_RWR = 0.
  localparam int RC_W = (T_RWR > 0) ? $clog2(T_RWR + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [RC_W-1:0]     rec_q, rec_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_write;
  logic [LEN_W-1:0]    sel_len;
  logic [CS_W-1:0]     sel_cs;

  logic [NR_REQ-1:0]   ready_c;
  logic                valid_c;
  logic                timeout_c;
  logic                end_busy;

  // Round-robin winner: first valid requester scanning upward from rr_ptr.
  always_comb begin
    int k;
    k         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      k = (int'(rr_ptr_q) + i) % NR_REQ;
      if (!win_found && req_valid_i[k]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(k);
      end
    end
  end

  // Mux the winner's request fields out of the packed buses.
  always_comb begin
    sel_addr  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
    sel_write = req_write_i[win_idx];
    sel_len   = req_len_i[int'(win_idx)*LEN_W +: LEN_W];
    sel_cs    = req_cs_i[int'(win_idx)*CS_W +: CS_W];
  end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_hit;

  // Watchdog counts BUSY cycles and reads zero on the first BUSY cycle.
  always_comb begin
    wdog_d = '0;
    if (state_q == BUSY) wdog_d = wdog_q + 1'b1;
  end

  assign wdog_hit = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  logic wdog_hit;
  assign wdog_hit = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    write_d   = write_q;
    len_d     = len_q;
    cs_d      = cs_q;
    id_d      = id_q;
    rec_d     = rec_q;
    ready_c   = '0;
    valid_c   = 1'b0;
    timeout_c = 1'b0;
    end_busy  = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          ready_c[win_idx] = 1'b1;
          if (win_idx == ID_W'(NR_REQ - 1)) rr_ptr_d = '0;
          else                              rr_ptr_d = win_idx + 1'b1;
          // A zero-length burst is consumed without touching the engine.
          if (sel_len != '0) begin
            addr_d  = sel_addr;
            write_d = sel_write;
            len_d   = sel_len;
            cs_d    = sel_cs;
            id_d    = win_idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        valid_c = 1'b1;
        if (txn_ready_i) state_d = BUSY;
      end
      BUSY: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (txn_done_i) begin
          end_busy = 1'b1;
        end else if (wdog_hit) begin
          end_busy  = 1'b1;
          timeout_c = 1'b1;
        end
      end
      RECOVER: begin
        if (rec_q <= RC_W'(1)) begin
          state_d = IDLE;
          id_d    = '0;
        end else begin
          rec_d = rec_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = '0;
      end
    endcase

    if (end_busy) begin
      if (T_RWR == 0) begin
        state_d = IDLE;
        id_d    = '0;
      end else begin
        state_d = RECOVER;
        rec_d   = RC_W'(T_RWR);
      end
    end
  end

  // State, pointer and captured command registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      len_q    <= '0;
      cs_q     <= '0;
      id_q     <= '0;
      rec_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      len_q    <= len_d;
      cs_q     <= cs_d;
      id_q     <= id_d;
      rec_q    <= rec_d;
    end
  end

  // Ready is combinational from req_valid_i; gate it so reset forces it low.
  assign req_ready_o = ready_c & {NR_REQ{rst_ni}};
  assign txn_valid_o = valid_c;
  assign txn_addr_o  = addr_q;
  assign txn_write_o = write_q;
  assign txn_len_o   = len_q;
  assign txn_cs_o    = cs_q;
  assign txn_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = timeout_c;

endmodule

// File: tb/tb_hyperbus_txn_arbiter.sv
// Directed testbench for hyperbus_txn_arbiter (NR_REQ=3, T_RWR=4,
// TIMEOUT_CYCLES=16). Inputs change 1 ns after the rising edge; outputs are
// sampled either then or on the falling edge.
module tb_hyperbus_txn_arbiter;

  localparam int NR_REQ = 3;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int CS_W   = 1;
  localparam int ID_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NR_REQ-1:0]        req_valid;
  logic [NR_REQ-1:0]        req_ready;
  logic [NR_REQ*ADDR_W-1:0] req_addr;
  logic [NR_REQ-1:0]        req_write;
  logic [NR_REQ*LEN_W-1:0]  req_len;
  logic [NR_REQ*CS_W-1:0]   req_cs;
  logic                     txn_valid;
  logic                     txn_ready;
  logic [ADDR_W-1:0]        txn_addr;
  logic                     txn_write;
  logic [LEN_W-1:0]         txn_len;
  logic [CS_W-1:0]          txn_cs;
  logic [ID_W-1:0]          txn_id;
  logic                     txn_done;
  logic                     busy;
  logic                     timeout;

  int total = 0;
  int bad   = 0;

  hyperbus_txn_arbiter #(
    .NR_REQ(NR_REQ), .NR_CS(2), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .T_RWR(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write),
    .req_len_i(req_len), .req_cs_i(req_cs),
    .txn_valid_o(txn_valid), .txn_ready_i(txn_ready),
    .txn_addr_o(txn_addr), .txn_write_o(txn_write),
    .txn_len_o(txn_len), .txn_cs_o(txn_cs), .txn_id_o(txn_id),
    .txn_done_i(txn_done), .busy_o(busy), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic v, input logic [31:0] a,
                         input logic w, input logic [15:0] l, input logic c);
    req_valid[k]            = v;
    req_addr[k*ADDR_W +: ADDR_W] = a;
    req_write[k]            = w;
    req_len[k*LEN_W +: LEN_W] = l;
    req_cs[k]               = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      step();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // From ISSUE: let the engine accept, pulse done, wait out recovery.
  task automatic finish_txn(input string tag);
    txn_ready = 1'b1;
    step();
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    wait_idle(tag, 20);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic seen_to;
    int   n;

    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_len   = '0;
    req_cs    = '0;
    txn_ready = 1'b0;
    txn_done  = 1'b0;

    // Reset state.
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", txn_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_id", txn_id, 0);
    chk("rst_addr", txn_addr, 0);
    chk("rst_timeout", timeout, 0);
    do_reset();

    // Single request from requester 1.
    set_req(1, 1'b1, 32'h0000_1000, 1'b1, 16'd8, 1'b1);
    txn_ready = 1'b1;
    smp();
    chk("s_ready", req_ready, 3'b010);
    chk("s_idle_valid", txn_valid, 0);
    step();
    req_valid = '0;
    smp();
    chk("s_valid", txn_valid, 1);
    chk("s_addr", txn_addr, 32'h0000_1000);
    chk("s_write", txn_write, 1);
    chk("s_len", txn_len, 8);
    chk("s_cs", txn_cs, 1);
    chk("s_id", txn_id, 1);
    chk("s_noready", req_ready, 0);
    step();
    smp();
    chk("s_busy_valid", txn_valid, 0);
    chk("s_busy", busy, 1);
    step();
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("s_rec%0d", i), busy, 1);
      chk($sformatf("s_rec_id%0d", i), txn_id, 1);
      step();
    end
    smp();
    chk("s_idle", busy, 0);
    chk("s_id_clr", txn_id, 0);

    // Contention: all three valid from reset.
    set_req(0, 1'b1, 32'hA000_0000, 1'b0, 16'd4, 1'b0);
    set_req(1, 1'b1, 32'hA000_0100, 1'b1, 16'd4, 1'b1);
    set_req(2, 1'b1, 32'hA000_0200, 1'b0, 16'd4, 1'b0);
    txn_ready = 1'b1;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      n = 0;
      while (!txn_valid && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("c_id%0d", t), txn_id, t % 3);
      chk($sformatf("c_addr%0d", t), txn_addr, 32'hA000_0000 + 32'h100 * (t % 3));
      step();
      txn_done = 1'b1;
      step();
      txn_done = 1'b0;
    end
    req_valid = '0;
    wait_idle("c_idle", 20);

    // Back-pressure: engine stalls for several cycles in ISSUE.
    do_reset();
    txn_ready = 1'b0;
    set_req(0, 1'b1, 32'h0000_2468, 1'b0, 16'd5, 1'b0);
    smp();
    chk("bp_ready", req_ready, 3'b001);
    step();
    set_req(0, 1'b0, 32'hDEAD_BEEF, 1'b1, 16'd9, 1'b1);
    set_req(2, 1'b1, 32'h0000_7777, 1'b1, 16'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp();
      chk($sformatf("bp_valid%0d", i), txn_valid, 1);
      chk($sformatf("bp_addr%0d", i), txn_addr, 32'h0000_2468);
      chk($sformatf("bp_len%0d", i), txn_len, 5);
      chk($sformatf("bp_write%0d", i), txn_write, 0);
      chk($sformatf("bp_id%0d", i), txn_id, 0);
      chk($sformatf("bp_ready%0d", i), req_ready, 0);
      step();
    end
    txn_ready = 1'b1;
    step();
    smp();
    chk("bp_busy_valid", txn_valid, 0);
    chk("bp_busy", busy, 1);
    req_valid = '0;
    step();
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    wait_idle("bp_idle", 20);

    // Zero length: move rr_ptr to 2 first with a normal requester-1 txn.
    set_req(1, 1'b1, 32'h0000_0040, 1'b0, 16'd2, 1'b0);
    step();
    req_valid = '0;
    finish_txn("z_pre_idle");
    set_req(2, 1'b1, 32'h0000_3000, 1'b0, 16'd0, 1'b0);
    smp();
    chk("z_ready", req_ready, 3'b100);
    chk("z_novalid", txn_valid, 0);
    step();
    set_req(2, 1'b1, 32'h0000_3300, 1'b0, 16'd4, 1'b0);
    set_req(0, 1'b1, 32'h3000_0000, 1'b1, 16'd6, 1'b1);
    smp();
    chk("z_stay_idle", busy, 0);
    chk("z_novalid2", txn_valid, 0);
    chk("z_next_ready", req_ready, 3'b001);
    step();
    req_valid = '0;
    smp();
    chk("z_next_valid", txn_valid, 1);
    chk("z_next_id", txn_id, 0);
    chk("z_next_addr", txn_addr, 32'h3000_0000);
    finish_txn("z_idle");

    // Watchdog: engine never reports done.
    set_req(1, 1'b1, 32'h0000_5000, 1'b0, 16'd8, 1'b0);
    txn_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    chk("wd_enter_busy", busy, 1);
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    n = 1;
    while (!timeout && n < 40) begin
      step();
      n++;
    end
    chk("wd_cycle", n, 16);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wd_rec%0d", i), busy, 1);
      chk($sformatf("wd_pulse%0d", i), timeout, 0);
      step();
    end
    chk("wd_idle", busy, 0);
`else
    seen_to = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_to = seen_to | timeout;
      step();
    end
    chk("wd_no_pulse", seen_to, 0);
    chk("wd_still_busy", busy, 1);
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    wait_idle("wd_idle", 20);
`endif

    // Reset while BUSY, then requester 0 must win first.
    set_req(1, 1'b1, 32'h0000_6000, 1'b1, 16'd7, 1'b1);
    txn_ready = 1'b1;
    step();
    step();
    chk("r_busy_pre", busy, 1);
    chk("r_id_pre", txn_id, 1);
    set_req(0, 1'b1, 32'h0000_0AA0, 1'b0, 16'd3, 1'b0);
    set_req(2, 1'b1, 32'h0000_0CC0, 1'b0, 16'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_valid", txn_valid, 0);
    chk("r_ready", req_ready, 0);
    chk("r_id", txn_id, 0);
    chk("r_addr", txn_addr, 0);
    chk("r_len", txn_len, 0);
    chk("r_write", txn_write, 0);
    chk("r_cs", txn_cs, 0);
    step();
    rst_n = 1'b1;
    smp();
    chk("r_first_ready", req_ready, 3'b001);
    step();
    req_valid = '0;
    smp();
    chk("r_first_id", txn_id, 0);
    chk("r_first_addr", txn_addr, 32'h0000_0AA0);
    finish_txn("r_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
